offchip_mem_model: RTL and testbench
====================================

OFFCHIP_MEM_MODEL -- requirements
Module: offchip_mem_model

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent request channels.
REQ-002 SHALL have parameter ADDR_W, default 7, channel address width.
REQ-003 SHALL have parameter DATA_W, default 8, channel data width; SIZE_W = clog2(DATA_W)+1.
REQ-004 SHALL have parameter DEPTH, default 32, words of storage; BASE_ADDR, default 0, first mapped address.
REQ-005 SHALL have parameters RD_LAT, default 2, and WR_LAT, default 1, each in cycles with a minimum of 1.
REQ-006 SHALL have port clock, in, 1, the single clock; every flop samples on its rising edge.
REQ-007 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-008 SHALL have ports oe and we, in, N_CH, per-channel read enable and write enable.
REQ-009 SHALL have port addr, in, N_CH*ADDR_W, packed per-channel address.
REQ-010 SHALL have port wdata, in, N_CH*DATA_W, packed per-channel write data.
REQ-011 SHALL have port size, in, N_CH*SIZE_W, packed per-channel access width in bits.
REQ-012 SHALL have port rdata, out, N_CH*DATA_W, packed per-channel read data.
REQ-013 SHALL have port data_rdy, out, N_CH, per-channel completion pulse.
REQ-014 SHALL have ports init_we, in, 1; init_addr, in, clog2(DEPTH); init_data, in, DATA_W: the backdoor preload port.
REQ-015 SHALL have port err, out, 1, sticky protocol-error flag.

Function
REQ-016 An address is in range iff BASE_ADDR <= addr < BASE_ADDR+DEPTH; the word index is addr-BASE_ADDR.
REQ-017 Each channel SHALL run an FSM with states IDLE, RD_WAIT, WR_WAIT and a latency counter.
REQ-018 IDLE->RD_WAIT on oe=1 with an in-range address; IDLE->WR_WAIT on we=1 with an in-range address; the address, size and wdata are captured at that edge.
REQ-019 Read: data_rdy=1 for exactly one cycle, RD_LAT cycles after the capture edge; rdata is the stored word masked to size bits during that cycle and 0 in every other cycle; the FSM then returns to IDLE.
REQ-020 Write: at the edge ending WR_LAT cycles after capture, store (wdata & m) | (old & ~m), where m = low size bits; pulse data_rdy in that same cycle; return to IDLE.
REQ-021 size=0 or size>=DATA_W SHALL mean full width.
REQ-022 Requester holds oe/we until data_rdy; dropping the enable during a WAIT state aborts the access: return to IDLE, no data_rdy, no memory update.
REQ-023 A new request SHALL be accepted on the cycle after a data_rdy pulse; back-to-back throughput is 1 access per LAT+1 cycles.
REQ-024 Out-of-range requests SHALL be ignored: no state change, data_rdy=0, rdata=0.
REQ-025 Same-edge writes from several channels to one word SHALL apply in ascending channel order, so the highest index wins.
REQ-026 A read sampling a word on the same edge it is written SHALL return the pre-write value.
REQ-027 A preload write (init_we) SHALL take priority over a channel write to the same word on the same edge.
REQ-028 oe=1 and we=1 on the same channel in the same cycle SHALL set err; that channel ignores the request.

Reset
REQ-029 reset=0 SHALL force all FSMs to IDLE, clear all counters, and drive data_rdy=0, rdata=0 and err=0, all asynchronously; memory contents are not cleared.
REQ-030 Reset asserted mid-access SHALL drop the access with no memory update; the requester must reissue it.

Configuration
REQ-031 With OFFCHIP_MEM_STATS_EN defined, ports rd_cnt and wr_cnt (out, N_CH*32) SHALL count completed reads and writes per channel, saturating at 2^32-1 and cleared by reset.
REQ-032 Without OFFCHIP_MEM_STATS_EN, those ports and their counters SHALL be absent.

Structure
REQ-033 Package offchip_mem_pkg SHALL hold the channel state enum and a size-to-mask function.
REQ-034 Sub-module offchip_mem_chan SHALL implement one channel's FSM and latency counter; it is instantiated N_CH times by generate.
REQ-035 Storage and the write-merge logic SHALL stay in the top module.

Verification
REQ-036 Preload word 3=0xA5, then read ch0 addr 3 (RD_LAT=2) -> data_rdy[0] high exactly 2 cycles after capture with rdata=0xA5, 0 otherwise.
REQ-037 Word 5=0xFF, write ch1 addr 5 wdata 0x00 size 4 -> word 5 = 0xF0; data_rdy[1] pulses after 1 cycle.
REQ-038 Ch0 and ch1 write word 7 with 0x11 and 0x22 on the same edge -> word 7 = 0x22.
REQ-039 Read addr 40 with DEPTH=32 -> no data_rdy for 10 cycles, rdata=0.
REQ-040 oe[0]=we[0]=1 -> err=1 and stays 1 until reset=0.
REQ-041 reset=0 during RD_WAIT -> data_rdy stays 0; after release, the next read completes in RD_LAT cycles.

Source files
------------

// File: rtl/offchip_mem_pkg.sv
// offchip_mem_pkg: shared channel state type and access-width helper
// for the off-chip memory model.
package offchip_mem_pkg;

  // Widest data word the mask helper supports.
  localparam int MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } chan_state_e;

  // Ones in the low size_bits positions of a data_w-bit word.
  // A size of 0, or one at least as wide as the word, selects the full word.
  function automatic logic [MAX_DATA_W-1:0] size_mask(input int unsigned size_bits,
                                                     input int unsigned data_w);
    logic [MAX_DATA_W-1:0] full_mask;
    full_mask = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - data_w);
    if (size_bits == 0 || size_bits >= data_w) return full_mask;
    return (MAX_DATA_W'(1) << size_bits) - MAX_DATA_W'(1);
  endfunction

endpackage

// File: rtl/offchip_mem_chan.sv
// offchip_mem_chan: one request channel of the off-chip memory model.
// Holds the IDLE/RD_WAIT/WR_WAIT state machine, the latency counter and
// the request fields captured at acceptance. The storage array lives in
// the parent; this block only tells it which word to sample or update.
module offchip_mem_chan
  import offchip_mem_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int DEPTH     = 32,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1,
  parameter int IDX_W     = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              oe,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SIZE_W-1:0] size,
  output logic              data_rdy,
  output logic              rd_fire,
  output logic              wr_fire,
  output logic              conflict,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] wdata_q,
  output logic [DATA_W-1:0] mask_q
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  chan_state_e       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] mask_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              capture;

  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx_in;
  logic [DATA_W-1:0] mask_in;

  // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
  assign offset   = 32'(addr) - 32'(BASE_ADDR);
  assign in_range = offset < 32'(DEPTH);
  assign idx_in   = offset[IDX_W-1:0];
  assign mask_in  = DATA_W'(size_mask(32'(size), DATA_W));
  assign conflict = oe & we;

  // Next state: accept in IDLE, count down in WAIT, abort when the enable drops.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (oe && !we && in_range) begin
          state_next = RD_WAIT;
          cnt_next   = CNT_W'(RD_LAT - 1);
          capture    = 1'b1;
        end else if (we && !oe && in_range) begin
          state_next = WR_WAIT;
          cnt_next   = CNT_W'(WR_LAT - 1);
          capture    = 1'b1;
        end
      end
      RD_WAIT: begin
        if (!oe) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          rd_fire    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (!we) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          wr_fire    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and latency counter; reset drops any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request fields frozen at acceptance so the requester may change them later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_reg   <= '0;
      mask_reg  <= '0;
      wdata_reg <= '0;
    end else if (capture) begin
      idx_reg   <= idx_in;
      mask_reg  <= mask_in;
      wdata_reg <= wdata;
    end
  end

  // While idle the live address is presented so a 1-cycle read samples at acceptance.
  assign mem_idx  = (state_reg == IDLE) ? idx_in : idx_reg;
  assign mask_q   = mask_reg;
  assign wdata_q  = wdata_reg;
  assign data_rdy = rd_fire | wr_fire;

endmodule

// File: rtl/offchip_mem_model.sv
// offchip_mem_model: multi-channel latency model of an off-chip memory.
// Each channel runs an offchip_mem_chan FSM; storage, write merging,
// preload and the sticky error flag live here.
// Optional build macro: OFFCHIP_MEM_STATS_EN adds per-channel rd_cnt/wr_cnt
// completion counters (saturating, 32 bits each).
module offchip_mem_model
  import offchip_mem_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1,
  localparam int SIZE_W   = $clog2(DATA_W) + 1,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_CH-1:0]        oe,
  input  logic [N_CH-1:0]        we,
  input  logic [N_CH*ADDR_W-1:0] addr,
  input  logic [N_CH*DATA_W-1:0] wdata,
  input  logic [N_CH*SIZE_W-1:0] size,
  output logic [N_CH*DATA_W-1:0] rdata,
  output logic [N_CH-1:0]        data_rdy,
  input  logic                   init_we,
  input  logic [IDX_W-1:0]       init_addr,
  input  logic [DATA_W-1:0]      init_data,
  output logic                   err
`ifdef OFFCHIP_MEM_STATS_EN
  ,
  output logic [N_CH*32-1:0]     rd_cnt,
  output logic [N_CH*32-1:0]     wr_cnt
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word_reg [N_CH];

  logic [N_CH-1:0]   rd_fire;
  logic [N_CH-1:0]   wr_fire;
  logic [N_CH-1:0]   conflict;
  logic [IDX_W-1:0]  mem_idx [N_CH];
  logic [DATA_W-1:0] wdata_q [N_CH];
  logic [DATA_W-1:0] mask_q  [N_CH];
  logic              err_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    offchip_mem_chan #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .SIZE_W    (SIZE_W),
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE_ADDR),
      .RD_LAT    (RD_LAT),
      .WR_LAT    (WR_LAT),
      .IDX_W     (IDX_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .oe       (oe[gi]),
      .we       (we[gi]),
      .addr     (addr[gi*ADDR_W +: ADDR_W]),
      .wdata    (wdata[gi*DATA_W +: DATA_W]),
      .size     (size[gi*SIZE_W +: SIZE_W]),
      .data_rdy (data_rdy[gi]),
      .rd_fire  (rd_fire[gi]),
      .wr_fire  (wr_fire[gi]),
      .conflict (conflict[gi]),
      .mem_idx  (mem_idx[gi]),
      .wdata_q  (wdata_q[gi]),
      .mask_q   (mask_q[gi])
    );

    // Read data is visible only in the completion cycle, trimmed to the access width.
    assign rdata[gi*DATA_W +: DATA_W] = rd_fire[gi] ? (rd_word_reg[gi] & mask_q[gi]) : '0;
  end

  // Storage update: channel merges in ascending order, preload applied last so it wins.
  always_ff @(posedge clock) begin
    for (int c = 0; c < N_CH; c++) begin
      if (wr_fire[c]) begin
        mem[mem_idx[c]] <= (wdata_q[c] & mask_q[c]) | (mem[mem_idx[c]] & ~mask_q[c]);
      end
    end
    if (init_we && ({1'b0, init_addr} < (IDX_W + 1)'(DEPTH))) begin
      mem[init_addr] <= init_data;
    end
  end

  // Registered per-channel read port; sees the word as it was before this edge's writes.
  always_ff @(posedge clock) begin
    for (int c = 0; c < N_CH; c++) begin
      rd_word_reg[c] <= mem[mem_idx[c]];
    end
  end

  // Sticky flag for a channel asking to read and write at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (|conflict) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

`ifdef OFFCHIP_MEM_STATS_EN
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_stats
    logic [31:0] rd_cnt_reg;
    logic [31:0] wr_cnt_reg;

    // Completed-access counters, holding at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_cnt_reg <= '0;
        wr_cnt_reg <= '0;
      end else begin
        if (rd_fire[gi] && (rd_cnt_reg != '1)) rd_cnt_reg <= rd_cnt_reg + 32'd1;
        if (wr_fire[gi] && (wr_cnt_reg != '1)) wr_cnt_reg <= wr_cnt_reg + 32'd1;
      end
    end

    assign rd_cnt[gi*32 +: 32] = rd_cnt_reg;
    assign wr_cnt[gi*32 +: 32] = wr_cnt_reg;
  end
`endif

endmodule

// File: tb/tb_offchip_mem_model.sv
// tb_offchip_mem_model: directed bench for offchip_mem_model with a
// transaction-level reference model and a per-cycle output compare.
module tb_offchip_mem_model;

  localparam int N_CH      = 2;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int SIZE_W    = 4;
  localparam int DEPTH     = 32;
  localparam int BASE_ADDR = 0;
  localparam int RD_LAT    = 2;
  localparam int WR_LAT    = 1;
  localparam int IDX_W     = 5;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_CH-1:0]        oe;
  logic [N_CH-1:0]        we;
  logic [N_CH*ADDR_W-1:0] addr;
  logic [N_CH*DATA_W-1:0] wdata;
  logic [N_CH*SIZE_W-1:0] size;
  logic [N_CH*DATA_W-1:0] rdata;
  logic [N_CH-1:0]        data_rdy;
  logic                   init_we;
  logic [IDX_W-1:0]       init_addr;
  logic [DATA_W-1:0]      init_data;
  logic                   err;

  offchip_mem_model #(
    .N_CH      (N_CH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .oe        (oe),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .rdata     (rdata),
    .data_rdy  (data_rdy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .err       (err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_done = 0;

  // Reference model state.
  logic [7:0] mmem [DEPTH];
  logic       exp_err = 1'b0;
  logic       rd_pend [N_CH] = '{default: 1'b0};
  int         rd_done [N_CH];
  int         rd_idx  [N_CH];
  logic [7:0] rd_mask [N_CH];
  logic [7:0] rd_exp  [N_CH];
  logic       wr_pend [N_CH] = '{default: 1'b0};
  int         wr_done [N_CH];
  int         wr_idx  [N_CH];
  logic [7:0] wr_val  [N_CH];
  logic [7:0] wr_mask [N_CH];

  function automatic logic [7:0] mask_of(input int sz);
    if (sz == 0 || sz >= DATA_W) return 8'hFF;
    return 8'((1 << sz) - 1);
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 13 + 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: at each edge, snapshot reads due next cycle, then apply writes/preload.
  initial begin
    forever begin
      @(posedge clock);
      for (int c = 0; c < N_CH; c++)
        if (rd_pend[c] && rd_done[c] == cyc + 1) rd_exp[c] = mmem[rd_idx[c]] & rd_mask[c];
      for (int c = 0; c < N_CH; c++)
        if (reset && wr_pend[c] && wr_done[c] == cyc)
          mmem[wr_idx[c]] = (wr_val[c] & wr_mask[c]) | (mmem[wr_idx[c]] & ~wr_mask[c]);
      if (init_we) mmem[init_addr] = init_data;
      if (!reset) exp_err = 1'b0;
      else if (|(oe & we)) exp_err = 1'b1;
      cyc = cyc + 1;
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clock);
      for (int c = 0; c < N_CH; c++) begin
        logic       er;
        logic [7:0] ed;
        er = (rd_pend[c] && rd_done[c] == cyc) || (wr_pend[c] && wr_done[c] == cyc);
        ed = (rd_pend[c] && rd_done[c] == cyc) ? rd_exp[c] : 8'h00;
        check($sformatf("data_rdy[%0d]", c), 32'(data_rdy[c]), 32'(er));
        check($sformatf("rdata[%0d]", c), 32'(rdata[c*DATA_W +: DATA_W]), 32'(ed));
      end
      check("err", 32'(err), 32'(reset ? exp_err : 1'b0));
    end
  end

  // One full-handshake access; returns observed data and latency (-1 if no data_rdy).
  task automatic access(input int ch, input bit is_wr, input int a, input logic [7:0] d,
                        input int sz, output logic [7:0] got, output int lat);
    int start;
    int l;
    l     = is_wr ? WR_LAT : RD_LAT;
    start = cyc;
    addr[ch*ADDR_W +: ADDR_W]  = ADDR_W'(a);
    wdata[ch*DATA_W +: DATA_W] = d;
    size[ch*SIZE_W +: SIZE_W]  = SIZE_W'(sz);
    if (a >= BASE_ADDR && a < BASE_ADDR + DEPTH) begin
      if (is_wr) begin
        wr_idx[ch] = a - BASE_ADDR; wr_val[ch] = d; wr_mask[ch] = mask_of(sz);
        wr_done[ch] = start + l; wr_pend[ch] = 1'b1;
      end else begin
        rd_idx[ch] = a - BASE_ADDR; rd_mask[ch] = mask_of(sz);
        rd_done[ch] = start + l; rd_pend[ch] = 1'b1;
      end
    end
    if (is_wr) we[ch] = 1'b1;
    else oe[ch] = 1'b1;
    got = 8'h00;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (data_rdy[ch]) begin
        lat = cyc - start;
        got = rdata[ch*DATA_W +: DATA_W];
        last_done = cyc;
        break;
      end
    end
    @(posedge clock); #1;
    oe[ch] = 1'b0;
    we[ch] = 1'b0;
    rd_pend[ch] = 1'b0;
    wr_pend[ch] = 1'b0;
    $display("access ch=%0d %s addr=%0d wdata=0x%0h size=%0d -> rdata=0x%0h latency=%0d",
             ch, is_wr ? "WR" : "RD", a, d, sz, got, lat);
  endtask

  task automatic preload(input int i, input logic [7:0] d);
    init_we = 1'b1; init_addr = IDX_W'(i); init_data = d;
    @(posedge clock); #1;
    init_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] g0, g1;
    int l0, l1, d1;
    reset = 1'b0; oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    @(posedge clock); #1;

    // Preload during reset: memory is independent of reset.
    for (int i = 0; i < DEPTH; i++) preload(i, pat(i));
    preload(3, 8'hA5);
    preload(5, 8'hFF);
    @(negedge clock);
    check("rst_data_rdy", 32'(data_rdy), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic read with RD_LAT=2.
    access(0, 1'b0, 3, 8'h00, 0, g0, l0);
    check("rd3_data", 32'(g0), 32'hA5);
    check("rd3_lat", 32'(l0), 32'd2);

    // Partial write on ch1, then read back.
    access(1, 1'b1, 5, 8'h00, 4, g0, l0);
    check("wr5_lat", 32'(l0), 32'd1);
    check("model_w5", 32'(mmem[5]), 32'hF0);
    access(0, 1'b0, 5, 8'h00, 8, g0, l0);
    check("rd5_data", 32'(g0), 32'hF0);

    // Narrow read.
    access(1, 1'b0, 3, 8'h00, 4, g0, l0);
    check("rd3_nib", 32'(g0), 32'h05);

    // Same-edge writes to one word: ch1 wins.
    fork
      access(0, 1'b1, 7, 8'h11, 0, g0, l0);
      access(1, 1'b1, 7, 8'h22, 0, g1, l1);
    join
    check("model_w7", 32'(mmem[7]), 32'h22);
    access(0, 1'b0, 7, 8'h00, 0, g0, l0);
    check("rd7_data", 32'(g0), 32'h22);

    // Read sampling on the same edge as a write returns the old word.
    fork
      access(0, 1'b0, 9, 8'h00, 0, g0, l0);
      access(1, 1'b1, 9, 8'h3C, 0, g1, l1);
    join
    check("rw9_old", 32'(g0), 32'h7A);
    access(0, 1'b0, 9, 8'h00, 0, g0, l0);
    check("rd9_new", 32'(g0), 32'h3C);

    // Preload beats a channel write to the same word on the same edge.
    fork
      access(0, 1'b1, 11, 8'h77, 0, g0, l0);
      begin @(posedge clock); #1; preload(11, 8'h5A); end
    join
    access(1, 1'b0, 11, 8'h00, 0, g0, l0);
    check("rd11_pre", 32'(g0), 32'h5A);

    // Out-of-range read is ignored.
    access(0, 1'b0, 40, 8'h00, 0, g0, l0);
    check("oor_lat", 32'(l0), 32'hFFFF_FFFF);
    check("oor_data", 32'(g0), 32'h0);

    // Aborted write (ch0) and aborted read (ch1): no data_rdy, no update.
    addr[0 +: ADDR_W] = 7'd13; wdata[0 +: DATA_W] = 8'h00; size[0 +: SIZE_W] = '0;
    addr[ADDR_W +: ADDR_W] = 7'd3;
    we[0] = 1'b1; oe[1] = 1'b1;
    @(posedge clock); #1;
    we[0] = 1'b0; oe[1] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    access(0, 1'b0, 13, 8'h00, 0, g0, l0);
    check("abort13", 32'(g0), 32'hAE);

    // Back-to-back reads: one access per RD_LAT+1 cycles.
    access(1, 1'b0, 3, 8'h00, 0, g0, l0);
    d1 = last_done;
    access(1, 1'b0, 3, 8'h00, 0, g1, l1);
    check("b2b_period", 32'(last_done - d1), 32'd3);

    // oe and we together: sticky err, request ignored.
    addr[0 +: ADDR_W] = 7'd3;
    oe[0] = 1'b1; we[0] = 1'b1;
    @(posedge clock); #1;
    oe[0] = 1'b0; we[0] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("err_sticky", 32'(err), 32'h1);
    @(posedge clock); #1;

    // Reset during RD_WAIT drops the access and clears err.
    addr[0 +: ADDR_W] = 7'd3; size[0 +: SIZE_W] = '0;
    oe[0] = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_rdy", 32'(data_rdy[0]), 32'h0);
    check("rst_mid_err", 32'(err), 32'h0);
    @(negedge clock);
    check("rst_mid_rdy2", 32'(data_rdy[0]), 32'h0);
    @(posedge clock); #1;
    oe[0] = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    access(0, 1'b0, 3, 8'h00, 0, g0, l0);
    check("post_rst_lat", 32'(l0), 32'd2);
    check("post_rst_data", 32'(g0), 32'hA5);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
